// File: rtl/vga_capture_rx.sv
// ----------------------------------------------------------------------------
// vga_capture_rx
//
// Receives a TinyVGA-style 8-pin video stream (2 bits per colour plus
// active-low hsync/vsync) and rebuilds the raster position from the sync
// edges alone. It verifies that line length and line count match the
// configured timing, holds a lock flag while they do, and produces a simple
// additive checksum of every frame that is fully received while locked.
//
// Ports
//   clk         pixel clock; the only clock, rising edge
//   rst_n       asynchronous active-low reset
//   pmod_in     {hsync, B0, G0, R0, vsync, B1, G1, R1}; syncs active-low
//   locked      timing lock achieved
//   pix_valid   output pixel is inside the active area while locked
//   pix_x       recovered horizontal position
//   pix_y       recovered vertical position
//   rgb         {R1,R0,G1,G0,B1,B0} of the sampled pixel (always passed on)
//   frame_sum   checksum of the last frame completed while locked
//   frame_done  one-cycle pulse when frame_sum updates
//   err_count   saturating count of lock losses
//
// Pin to output latency is two clocks: one input register stage, then all
// outputs are registered from logic that looks at that stage.
// ----------------------------------------------------------------------------
module vga_capture_rx #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_SYNC_START = 656,
    parameter int V_SYNC_START = 490
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pmod_in,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [5:0]  rgb,
    output logic [15:0] frame_sum,
    output logic        frame_done,
    output logic [7:0]  err_count
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int HS_BIT = 7;
    localparam int VS_BIT = 3;

    localparam logic [9:0]  X_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  X_SYNC      = 10'(H_SYNC_START);
    localparam logic [9:0]  Y_SYNC      = 10'(V_SYNC_START);
    localparam logic [9:0]  X_ACT       = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT       = 10'(V_ACTIVE);
    localparam logic [10:0] LINE_LEN    = 11'(H_TOTAL);
    localparam logic [10:0] FRAME_LINES = 11'(V_TOTAL);

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: input register plus the previous stage-1 sync levels.
    // Syncs reset to 1 so that no edge is seen straight out of reset.
    // ------------------------------------------------------------------
    logic [7:0] pin_p1;
    logic       hs_d_p1;
    logic       vs_d_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_p1  <= 8'h88;
            hs_d_p1 <= 1'b1;
            vs_d_p1 <= 1'b1;
        end else begin
            pin_p1  <= pmod_in;
            hs_d_p1 <= pin_p1[HS_BIT];
            vs_d_p1 <= pin_p1[VS_BIT];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: edge detection, position recovery, timing checks, FSM
    // and outputs, all registered at this boundary.
    // ------------------------------------------------------------------
    logic        hs_fall;
    logic        vs_fall;
    logic        x_wrap;
    logic [9:0]  x_next;
    logic [9:0]  y_next;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [10:0] line_cnt;
    logic        line_armed;
    logic        line_bad;
    logic [10:0] frame_lines;
    logic        frame_bad;
    logic        frame_good;
    logic        err_bump;
    logic [15:0] acc;

    always_comb begin
        hs_fall = hs_d_p1 & ~pin_p1[HS_BIT];
        vs_fall = vs_d_p1 & ~pin_p1[VS_BIT];

        // An hsync fall re-phases x, so it never counts as a wrap.
        x_wrap = ~hs_fall & (pix_x == X_LAST);

        if (hs_fall) begin
            x_next = X_SYNC;
        end else if (x_wrap) begin
            x_next = 10'd0;
        end else begin
            x_next = pix_x + 10'd1;
        end

        if (vs_fall) begin
            y_next = Y_SYNC;
        end else if (x_wrap) begin
            y_next = (pix_y == Y_LAST) ? 10'd0 : pix_y + 10'd1;
        end else begin
            y_next = pix_y;
        end

        // line_cnt holds the length of the line that ends at this fall.
        line_bad   = hs_fall & line_armed & (line_cnt != LINE_LEN);
        frame_good = ~frame_bad & ~line_bad & (frame_lines == FRAME_LINES);
    end

    always_comb begin
        state_next = state;
        err_bump   = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A failed frame simply restarts the measurement here.
                if (vs_fall && frame_good) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (line_bad) begin
                    state_next = ST_MEASURE;
                    err_bump   = 1'b1;
                end else if (vs_fall && (frame_lines != FRAME_LINES)) begin
                    state_next = ST_MEASURE;
                    err_bump   = 1'b1;
                end
            end
            default: begin
                state_next = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SEARCH;
            line_cnt    <= 11'd0;
            line_armed  <= 1'b0;
            frame_lines <= 11'd0;
            frame_bad   <= 1'b0;
            acc         <= 16'd0;
        end else begin
            state <= state_next;

            // The fall cycle itself is the first cycle of the new line, so a
            // nominal line reads exactly H_TOTAL at its closing fall.
            line_cnt <= hs_fall ? 11'd1 : sat_inc11(line_cnt);

            // On entry to MEASURE the line in progress is partial; the next
            // hsync fall only establishes a reference.
            if ((state_next == ST_MEASURE) && (state != ST_MEASURE)) begin
                line_armed <= 1'b0;
            end else if (hs_fall && (state != ST_SEARCH)) begin
                line_armed <= 1'b1;
            end

            // A coincident hsync fall belongs to the frame that is starting.
            if (vs_fall) begin
                frame_lines <= hs_fall ? 11'd1 : 11'd0;
            end else if (hs_fall) begin
                frame_lines <= sat_inc11(frame_lines);
            end

            // A mid-frame drop leaves frame_bad set, which forces the
            // partial frame that follows to be discarded.
            frame_bad <= vs_fall ? 1'b0 : (frame_bad | line_bad);

            if (vs_fall) begin
                acc <= 16'd0;
            end else if (pix_valid) begin
                acc <= acc + {10'd0, rgb};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked     <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= 10'd0;
            pix_y      <= 10'd0;
            rgb        <= 6'd0;
            frame_sum  <= 16'd0;
            frame_done <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            locked    <= (state_next == ST_LOCKED);
            pix_valid <= (state_next == ST_LOCKED) && (x_next < X_ACT) && (y_next < Y_ACT);
            pix_x     <= x_next;
            pix_y     <= y_next;
            rgb       <= {pin_p1[0], pin_p1[4], pin_p1[1], pin_p1[5], pin_p1[2], pin_p1[6]};

            if (vs_fall && (state == ST_LOCKED)) begin
                frame_sum  <= acc;
                frame_done <= 1'b1;
            end else begin
                frame_done <= 1'b0;
            end

            if (err_bump) begin
                err_count <= sat_inc8(err_count);
            end
        end
    end

endmodule

// File: doc/vga_capture_rx.md
VGA_CAPTURE_RX -- requirements
Module: vga_capture_rx

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-003 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-005 SHALL have parameter H_SYNC_START, default 656, pixel index at which hsync asserts.
REQ-006 SHALL have parameter V_SYNC_START, default 490, line index at which vsync asserts.
REQ-007 SHALL have port clk  input  1  pixel clock; all logic on its rising edge, one clock only.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port pmod_in  input  8  TinyVGA pins {hsync, B0, G0, R0, vsync, B1, G1, R1}; syncs active-low.
REQ-010 SHALL have port locked  output  1  timing lock achieved.
REQ-011 SHALL have port pix_valid  output  1  current output pixel is in the active area and locked is high.
REQ-012 SHALL have port pix_x  output  10  recovered horizontal position.
REQ-013 SHALL have port pix_y  output  10  recovered vertical position.
REQ-014 SHALL have port rgb  output  6  {R1,R0,G1,G0,B1,B0} of the sampled pixel.
REQ-015 SHALL have port frame_sum  output  16  checksum of the last completed frame.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when frame_sum updates.
REQ-017 SHALL have port err_count  output  8  saturating count of timing errors while locked.

Function
REQ-018 SHALL register pmod_in once (stage 1); edges SHALL be detected on the stage-1 value against its previous value; all outputs SHALL be registered, giving 2 cycles latency from pin to outputs.
REQ-019 SHALL detect a line start on a stage-1 hsync 1->0 transition; on that cycle x SHALL load H_SYNC_START; otherwise x SHALL increment, wrapping H_TOTAL-1 -> 0.
REQ-020 SHALL increment y whenever x wraps to 0, wrapping V_TOTAL-1 -> 0; a stage-1 vsync 1->0 transition SHALL load y with V_SYNC_START, taking priority over the increment.
REQ-021 SHALL measure each line length: an 11-bit counter cleared on each hsync fall, saturating at 2047; a line is bad if the count at the next hsync fall is not H_TOTAL.
REQ-022 SHALL count hsync falls between consecutive vsync falls; a frame is bad if any line was bad or the count is not V_TOTAL.
REQ-023 SHALL implement FSM SEARCH, MEASURE and LOCKED. SEARCH goes to MEASURE on a vsync fall. MEASURE goes to LOCKED on the next vsync fall if the frame was good; otherwise it stays in MEASURE and restarts the measurement. LOCKED goes to MEASURE on any bad line (immediately) or bad frame count (at vsync fall).
REQ-024 SHALL ignore the partial first line after entering MEASURE: the first hsync fall only arms the line check.
REQ-025 SHALL drive locked high only in LOCKED; pix_valid = locked and x < H_ACTIVE and y < V_ACTIVE.
REQ-026 SHALL increment err_count by 1 on each LOCKED->MEASURE transition, saturating at 255.
REQ-027 SHALL accumulate rgb (zero-extended) into a 16-bit wrapping accumulator on every pix_valid cycle.
REQ-028 On each vsync fall while LOCKED, SHALL copy the accumulator to frame_sum, clear the accumulator, and pulse frame_done for one cycle; the accumulator SHALL also be cleared on every vsync fall outside LOCKED.
REQ-029 When hsync and vsync fall on the same cycle, SHALL apply both REQ-019 and REQ-020 in that cycle.
REQ-030 rgb SHALL pass through regardless of lock state.

Reset
REQ-031 While rst_n is low, SHALL force: FSM=SEARCH, locked=0, pix_valid=0, pix_x=0, pix_y=0, rgb=0, frame_sum=0, frame_done=0, err_count=0, accumulator and counters=0, and stage-1 syncs=1 (inactive).
REQ-032 SHALL require no synchronous reset; reset asserted mid-frame SHALL return to SEARCH, and the block SHALL relock only after two subsequent vsync falls.

Verification
REQ-033 Check reset values: rst_n low with arbitrary pmod_in -> every output 0.
REQ-034 Lock: clean 800x525 stream from an hvsync model -> locked rises 2 cycles after the second vsync fall after reset; pix_x/pix_y track the generator with 2 cycles of delay.
REQ-035 Checksum: constant white (rgb=6'h3F) with lock held -> frame_sum = 16'h5000 (307200*63 mod 65536) with a one-cycle frame_done.
REQ-036 Timing error: one 801-cycle line while locked -> locked drops at that hsync fall, err_count=1, relocks after the next two vsync falls.
REQ-037 Boundary: hsync and vsync fall on the same cycle -> x=656 and y=490 on the next cycle; err_count held at 255 saturates under repeated errors.
REQ-038 Reset mid-frame while locked -> immediate reset values, no frame_done until relock plus one full frame.
